// File: rtl/mlp_result_framer.sv
`default_nettype none
// ============================================================================
// Module      : mlp_result_framer
// Description : Buffers MLP accumulator results {layer, acc0, acc1} in a small
//               FIFO and serializes each one as a fixed 10-byte frame on a
//               byte valid/ready stream feeding the UART transmitter.
//               Frame: HEADER, {5'b0,layer}, acc0[LE x4], acc1[LE x4].
//               Results arriving while the FIFO is full are dropped and
//               counted.
// Revision    : 1.0 - initial release
// ============================================================================
module mlp_result_framer #(
  parameter int         DEPTH  = 8,
  parameter logic [7:0] HEADER = 8'hA5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       acc_valid,
  input  logic [31:0]                acc0,
  input  logic [31:0]                acc1,
  input  logic [2:0]                 layer,
  input  logic                       flush,
  output logic                       out_valid,
  output logic [7:0]                 out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       overflow,
  output logic [7:0]                 drop_cnt
);

  // --------------------------------------------------------------------------
  // Local constants
  // --------------------------------------------------------------------------
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = 67;

  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
  localparam logic [3:0]       LAST_IDX = 4'd9;
  localparam logic [7:0]       DROP_MAX = 8'hFF;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;

  logic [0:0]         state;
  logic [0:0]         state_next;

  logic [ENTRY_W-1:0] frame;
  logic [ENTRY_W-1:0] frame_next;
  logic [3:0]         byte_idx;
  logic [3:0]         byte_idx_next;

  logic               out_valid_next;
  logic [7:0]         out_data_next;
  logic               out_last_next;

  logic               accept;
  logic               pop;
  logic               push;
  logic               drop;
  logic               full;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head_entry;

  // --------------------------------------------------------------------------
  // Frame byte selection: entry layout is {layer[66:64], acc0[63:32], acc1[31:0]}
  // --------------------------------------------------------------------------
  function automatic logic [7:0] frame_byte(input logic [ENTRY_W-1:0] ent,
                                            input logic [3:0]         idx);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = HEADER;
      4'd1:    b = {5'b00000, ent[66:64]};
      4'd2:    b = ent[39:32];
      4'd3:    b = ent[47:40];
      4'd4:    b = ent[55:48];
      4'd5:    b = ent[63:56];
      4'd6:    b = ent[7:0];
      4'd7:    b = ent[15:8];
      4'd8:    b = ent[23:16];
      4'd9:    b = ent[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // --------------------------------------------------------------------------
  // Handshake and FIFO control. A pop happens only when the final frame byte
  // is taken, so a full FIFO can still accept a result in that same cycle.
  // Flush swallows any concurrent result without counting it as a drop.
  // --------------------------------------------------------------------------
  assign accept     = out_valid & out_ready;
  assign pop        = accept & out_last;
  assign full       = (count == CNT_FULL);
  assign push       = acc_valid & ~flush & (~full | pop);
  assign drop       = acc_valid & ~flush & full & ~pop;
  assign wr_entry   = {layer, acc0, acc1};
  assign head_entry = mem[rd_ptr];
  assign empty      = (count == '0);

  // FIFO storage write; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // FIFO pointers and occupancy; both pointers may move in the same cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow flag and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != DROP_MAX) begin
        drop_cnt <= drop_cnt + 8'h01;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame serializer FSM
  // --------------------------------------------------------------------------

  // State register; flush and reset both abandon any frame in progress
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: start a frame whenever an entry is waiting
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          state_next = ST_SEND;
        end
      end
      ST_SEND: begin
        if (accept && (byte_idx == LAST_IDX)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered stream outputs and frame copy
  always_comb begin
    frame_next     = frame;
    byte_idx_next  = byte_idx;
    out_valid_next = out_valid;
    out_data_next  = out_data;
    out_last_next  = out_last;
    case (state)
      ST_IDLE: begin
        if (count != '0) begin
          frame_next     = head_entry;
          byte_idx_next  = 4'd0;
          out_valid_next = 1'b1;
          out_data_next  = HEADER;
          out_last_next  = 1'b0;
        end
      end
      ST_SEND: begin
        if (accept) begin
          if (byte_idx == LAST_IDX) begin
            byte_idx_next  = 4'd0;
            out_valid_next = 1'b0;
            out_data_next  = 8'h00;
            out_last_next  = 1'b0;
          end else begin
            byte_idx_next  = byte_idx + 4'd1;
            out_data_next  = frame_byte(frame, byte_idx + 4'd1);
            out_last_next  = ((byte_idx + 4'd1) == LAST_IDX);
          end
        end
      end
      default: begin
        byte_idx_next  = 4'd0;
        out_valid_next = 1'b0;
        out_data_next  = 8'h00;
        out_last_next  = 1'b0;
      end
    endcase
  end

  // Registered stream outputs and frame copy; held while stalled
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      frame     <= '0;
      byte_idx  <= 4'd0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
    end else begin
      frame     <= frame_next;
      byte_idx  <= byte_idx_next;
      out_valid <= out_valid_next;
      out_data  <= out_data_next;
      out_last  <= out_last_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mlp_result_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mlp_result_framer
// Description : Directed self-checking bench for mlp_result_framer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mlp_result_framer;

  logic        clk;
  logic        rst;
  logic        acc_valid;
  logic [31:0] acc0;
  logic [31:0] acc1;
  logic [2:0]  layer;
  logic        flush;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_ready;
  logic [3:0]  count;
  logic        empty;
  logic        overflow;
  logic [7:0]  drop_cnt;

  int total  = 0;
  int passed = 0;

  mlp_result_framer #(.DEPTH(8), .HEADER(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .acc_valid (acc_valid),
    .acc0      (acc0),
    .acc1      (acc1),
    .layer     (layer),
    .flush     (flush),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .count     (count),
    .empty     (empty),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected frame byte for a result
  function automatic logic [7:0] exp_byte(input logic [2:0] l, input logic [31:0] a0,
                                          input logic [31:0] a1, input int i);
    logic [7:0] b;
    case (i)
      0: b = 8'hA5;
      1: b = {5'b00000, l};
      2: b = a0[7:0];
      3: b = a0[15:8];
      4: b = a0[23:16];
      5: b = a0[31:24];
      6: b = a1[7:0];
      7: b = a1[15:8];
      8: b = a1[23:16];
      default: b = a1[31:24];
    endcase
    return b;
  endfunction

  task automatic push_one(input logic [2:0] l, input logic [31:0] a0, input logic [31:0] a1);
    acc_valid = 1'b1;
    layer     = l;
    acc0      = a0;
    acc1      = a1;
    step();
    acc_valid = 1'b0;
  endtask

  // Wait (bounded) for a frame, then check all 10 bytes with out_ready held high
  task automatic recv_frame(input logic [2:0] l, input logic [31:0] a0, input logic [31:0] a1);
    int waited = 0;
    while (!out_valid && waited < 20) begin
      step();
      waited++;
    end
    check("frame_start", out_valid, 1);
    for (int i = 0; i < 10; i++) begin
      check("frame_byte", out_data, exp_byte(l, a0, a1, i));
      check("frame_last", out_last, (i == 9));
      step();
    end
  endtask

  initial begin
    int idx;
    int cyc;
    logic [7:0] bp_exp [10];

    rst = 1'b1; acc_valid = 1'b0; acc0 = '0; acc1 = '0; layer = '0;
    flush = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data",  out_data,  0);
    check("rst_out_last",  out_last,  0);
    check("rst_count",     count,     0);
    check("rst_empty",     empty,     1);
    check("rst_overflow",  overflow,  0);
    check("rst_drop_cnt",  drop_cnt,  0);

    // Single result, header two cycles after the push
    out_ready = 1'b1;
    push_one(3'd2, 32'h11223344, 32'hFFFFFF80);
    check("single_count_after_push", count, 1);
    check("single_valid_n1", out_valid, 0);
    step();
    check("single_valid_n2", out_valid, 1);
    begin
      logic [7:0] exp_single [10];
      exp_single = '{8'hA5, 8'h02, 8'h44, 8'h33, 8'h22, 8'h11, 8'h80, 8'hFF, 8'hFF, 8'hFF};
      for (int i = 0; i < 10; i++) begin
        check("single_byte", out_data, exp_single[i]);
        check("single_last", out_last, (i == 9));
        check("single_count_during", count, 1);
        step();
      end
    end
    check("single_valid_after", out_valid, 0);
    check("single_count_after", count, 0);
    check("single_empty_after", empty, 1);

    // Backpressure: out_ready alternates every cycle
    bp_exp = '{8'hA5, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h04, 8'h03, 8'h02, 8'h01};
    push_one(3'd5, 32'hDEADBEEF, 32'h01020304);
    idx = 0;
    cyc = 0;
    while (idx < 10 && cyc < 60) begin
      out_ready = (cyc % 2 == 0);
      if (out_valid) begin
        check("bp_byte", out_data, bp_exp[idx]);
        check("bp_last", out_last, (idx == 9));
        if (out_ready) idx++;
      end
      step();
      cyc++;
    end
    check("bp_accepts", idx, 10);
    out_ready = 1'b1;
    check("bp_valid_after", out_valid, 0);
    step();
    check("bp_no_extra", out_valid, 0);
    check("bp_count_after", count, 0);

    // Overflow: 10 results into an 8-deep FIFO with the sink stalled
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      push_one(3'(i), 32'h10000000 + 32'(i), 32'hA0000000 + 32'(i));
    end
    check("ovf_count", count, 8);
    check("ovf_flag", overflow, 1);
    check("ovf_drop_cnt", drop_cnt, 2);
    check("ovf_empty", empty, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      recv_frame(3'(i), 32'h10000000 + 32'(i), 32'hA0000000 + 32'(i));
    end
    check("ovf_drained_count", count, 0);
    check("ovf_sticky", overflow, 1);
    check("ovf_drop_held", drop_cnt, 2);

    // Flush clears status
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_clr_overflow", overflow, 0);
    check("flush_clr_drop", drop_cnt, 0);

    // Full FIFO with a push coinciding with the final-byte accept
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_one(3'(i), 32'h20000000 + 32'(i), 32'hB0000000 + 32'(i));
    end
    check("fullpop_count_full", count, 8);
    check("fullpop_valid", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("fullpop_byte", out_data, exp_byte(3'd0, 32'h20000000, 32'hB0000000, i));
      check("fullpop_last", out_last, (i == 9));
      if (i == 9) begin
        acc_valid = 1'b1;
        layer     = 3'd7;
        acc0      = 32'hCAFEF00D;
        acc1      = 32'h80000001;
      end
      step();
    end
    acc_valid = 1'b0;
    check("fullpop_count_kept", count, 8);
    check("fullpop_no_overflow", overflow, 0);
    check("fullpop_no_drop", drop_cnt, 0);
    for (int i = 1; i < 8; i++) begin
      recv_frame(3'(i), 32'h20000000 + 32'(i), 32'hB0000000 + 32'(i));
    end
    recv_frame(3'd7, 32'hCAFEF00D, 32'h80000001);
    check("fullpop_drained", count, 0);

    // Flush mid-frame at byte 4 with a concurrent result
    push_one(3'd1, 32'h55667788, 32'h99AABBCC);
    push_one(3'd3, 32'h01010101, 32'h02020202);
    check("flush_frame_header", out_data, 8'hA5);
    for (int i = 0; i < 4; i++) step();
    check("flush_at_byte4", out_data, 8'h66);
    flush     = 1'b1;
    acc_valid = 1'b1;
    layer     = 3'd4;
    acc0      = 32'h12345678;
    acc1      = 32'h9ABCDEF0;
    step();
    flush     = 1'b0;
    acc_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_count", count, 0);
    check("flush_overflow", overflow, 0);
    check("flush_drop_cnt", drop_cnt, 0);
    check("flush_empty", empty, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("flush_quiet", out_valid, 0);
    end

    // Reset mid-frame with three entries queued
    out_ready = 1'b0;
    push_one(3'd1, 32'hAAAA0001, 32'hBBBB0001);
    push_one(3'd2, 32'hAAAA0002, 32'hBBBB0002);
    push_one(3'd3, 32'hAAAA0003, 32'hBBBB0003);
    step();
    out_ready = 1'b1;
    step(); step();
    check("rstmid_in_frame", out_valid, 1);
    check("rstmid_count_pre", count, 3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_out_data",  out_data,  0);
    check("rstmid_out_last",  out_last,  0);
    check("rstmid_count",     count,     0);
    check("rstmid_empty",     empty,     1);
    check("rstmid_overflow",  overflow,  0);
    check("rstmid_drop_cnt",  drop_cnt,  0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("rstmid_quiet", out_valid, 0);
    end
    push_one(3'd6, 32'h0BADCAFE, 32'hFEEDFACE);
    recv_frame(3'd6, 32'h0BADCAFE, 32'hFEEDFACE);
    check("rstmid_final_empty", empty, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mlp_result_framer.md
Name: mlp_result_framer

Overview:
- Downstream consumer of the MLP accumulator outputs.
- Captures each valid {layer, acc0, acc1} result into a small FIFO.
- Serializes each entry as a fixed 10-byte frame over a byte valid/ready stream, for the UART transmit path.
- Decouples bursty acc_valid pulses from the slow UART byte rate and reports dropped results.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- HEADER, 8'hA5, first byte of every frame.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- acc_valid  in  1  result strobe from MLP, one cycle per result
- acc0  in  32  signed column-0 accumulator
- acc1  in  32  signed column-1 accumulator
- layer  in  3  current layer index sampled with acc_valid
- flush  in  1  clear FIFO, abort frame, clear status
- out_valid  out  1  byte available
- out_data  out  8  frame byte
- out_last  out  1  high on byte 9 (final) of frame
- out_ready  in  1  downstream accepts byte when high with out_valid
- count  out  $clog2(DEPTH+1)  entries held, including the one being sent
- empty  out  1  count == 0
- overflow  out  1  sticky: a result was dropped
- drop_cnt  out  8  dropped results, saturates at 255

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_last=0, count=0, empty=1, overflow=0, drop_cnt=0.
  - FSM=IDLE; read/write pointers=0.
  - Reset mid-frame abandons the frame immediately.
- FIFO entry: 67 bits {layer, acc0, acc1}.
- Push on acc_valid when count<DEPTH, or when count==DEPTH and a pop happens in the same cycle.
- A rejected push sets overflow and increments drop_cnt (saturating). The stored entry is not modified.
- Pop occurs only on acceptance of the final frame byte (out_valid & out_ready & out_last). The entry stays at head for the whole frame.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo DEPTH.
- Frame byte order, index 0..9:
  - 0: HEADER
  - 1: {5'b0, layer}
  - 2-5: acc0 little-endian, [7:0] first
  - 6-9: acc1 little-endian
- FSM states:
  - IDLE: if count!=0, latch head entry into frame register, byte_idx=0, out_valid=1, go SEND. Else hold.
  - SEND: out_data/out_last driven from frame register and byte_idx. All outputs registered and stable while out_valid & !out_ready.
    - On accept with byte_idx<9: byte_idx+1.
    - On accept with byte_idx==9: pop, out_valid=0, go IDLE.
- Latency:
  - Push at cycle N, empty and idle → out_valid with HEADER at N+2.
  - With out_ready held high, one byte per cycle (10 cycles per frame).
  - One idle bubble cycle between consecutive frames.
- out_last = (byte_idx==9) & out_valid.
- flush (priority over everything):
  - Next cycle: count=0, pointers=0, FSM=IDLE, out_valid=0, overflow=0, drop_cnt=0.
  - acc_valid in the same cycle is discarded and not counted as a drop.
- acc_valid while a frame is in SEND is captured normally. The frame register is unaffected.
- out_ready while out_valid=0 is ignored.

Test Plan:
- Single result: layer=2, acc0=32'h11223344, acc1=32'hFFFFFF80, out_ready=1.
  - Required response: bytes A5,02,44,33,22,11,80,FF,FF,FF.
  - out_last only on 10th byte; HEADER at N+2; count 1→0 after last byte; empty=1.
- Backpressure: out_ready toggled 1-0-1 every cycle during a frame.
  - Required response: each byte held stable while stalled; exactly 10 accepts; no repeated or skipped bytes.
- Overflow: DEPTH=8, out_ready=0, 10 acc_valid pulses.
  - Required response: count=8, overflow=1, drop_cnt=2.
  - Releasing out_ready yields the first 8 results in order.
- Full with simultaneous pop: count=8, acc_valid coincides with last-byte accept.
  - Required response: push accepted, count stays 8, overflow stays 0, wrapped entry later emitted correctly.
- Flush mid-frame at byte 4 with acc_valid in the same cycle.
  - Required response: next cycle out_valid=0, count=0, overflow=0; no further bytes until a new acc_valid.
- rst asserted mid-frame with 3 entries queued.
  - Required response: all outputs return to reset values next cycle; next result after reset produces a clean frame starting with A5.
